key_filter_bank: RTL and testbench
==================================

# key_filter_bank

Parametrised multi-channel push-button front end for the clock's user panel. Each of `N_KEYS` raw button inputs is synchronised and debounced independently, then turned into a debounced level and one-cycle press and release events. An optional per-key long-press/auto-repeat generator drives fast time-setting. The block sits between the board pins and the time-set control FSM, and replaces the per-key single-channel debouncers.

## Interface
Parameters:
- `N_KEYS`, 4: number of independent key channels (≥1).
- `DEBOUNCE_CYC`, 1_000_000: consecutive stable cycles required to accept a new level (20 ms at 50 MHz; ≥1).
- `LONG_CYC`, 50_000_000: cycles a debounced key must stay pressed before `key_long` fires (≥1).
- `REPEAT_CYC`, 10_000_000: period of `key_repeat` pulses after a long press. 0 disables repeat.
- `ACTIVE_LOW`, 1: 1 means a raw pin reads 0 when pressed; 0 means it reads 1 when pressed.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `key`, in, `N_KEYS`: raw asynchronous button pins.
- `key_level`, out, `N_KEYS`: debounced state. 1 means pressed, independent of `ACTIVE_LOW`.
- `key_press`, out, `N_KEYS`: one-cycle pulse when `key_level` rises.
- `key_release`, out, `N_KEYS`: one-cycle pulse when `key_level` falls.
- `key_long`, out, `N_KEYS`: one-cycle pulse after `LONG_CYC` cycles held.
- `key_repeat`, out, `N_KEYS`: one-cycle pulse every `REPEAT_CYC` cycles while held past long.

## Operation
- **Synchroniser:** two flops per channel, `d0` then `d1`. Both reset to the released pin level (`ACTIVE_LOW` ? 1 : 0).
  - `raw` = `d1` mapped to logical pressed = 1.
- **Debounce counter:** width `$clog2(DEBOUNCE_CYC+1)`.
  - If `raw == key_level`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYC-1`: `key_level <= raw`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Any mismatch run shorter than `DEBOUNCE_CYC` cycles is discarded; the counter restarts from 0 on the next mismatch.
- **Event pulses:** `key_press` and `key_release` are registered in the same cycle as the `key_level` update. They are never both high on one channel in the same cycle.
- **Hold FSM** (per channel): states IDLE, HELD, LONG.
  - IDLE → HELD on `key_press`; clear `hold_cnt`.
  - HELD: increment `hold_cnt`. When `hold_cnt == LONG_CYC-1`, pulse `key_long`, go to LONG, clear `hold_cnt`.
  - LONG, if `REPEAT_CYC != 0`: increment `hold_cnt`. When `hold_cnt == REPEAT_CYC-1`, pulse `key_repeat` and clear `hold_cnt` (wraps indefinitely).
  - HELD or LONG → IDLE in the cycle `key_release` is asserted. No `key_long`/`key_repeat` pulse is emitted in that cycle, even if a count boundary coincides.
- **Counter width:** `hold_cnt` is `$clog2(max(LONG_CYC, REPEAT_CYC)+1)` bits. Counters saturate at no point; every terminal value is an explicit compare.
- **Channel independence:** channels share nothing. Simultaneous presses on several keys each produce their own pulses in the same cycle.
- **Reset:** all outputs reset to 0; all counters to 0; FSMs to IDLE. A reset mid-press discards the press.
  - After reset, a key still held produces `key_press` once `DEBOUNCE_CYC` cycles of pressed `raw` have accumulated.

## Timing
- Pin edge → `key_level` / `key_press`: 2 + `DEBOUNCE_CYC` cycles for a clean edge, counted from the first capturing edge into `d0`.
- `key_press` → `key_long`: `LONG_CYC` cycles.
- `key_long` → first `key_repeat`: `REPEAT_CYC` cycles. Subsequent repeats are spaced exactly `REPEAT_CYC` cycles.
- All outputs are registered. There is no combinational path from `key` to any output.

## Configuration
- **`KEY_LONG_PRESS_EN` defined:** Hold FSM and `hold_cnt` are built as described.
- **`KEY_LONG_PRESS_EN` undefined:** the FSM and counters are not instantiated, and `key_long` and `key_repeat` are tied to 0. `LONG_CYC` and `REPEAT_CYC` are ignored. The debounce path is unchanged.

## Structure
- **Shared package `key_pkg`:**
  - hold-state encodings `KEY_ST_IDLE=2'd0`, `KEY_ST_HELD=2'd1`, `KEY_ST_LONG=2'd2`;
  - default timing constants `KEY_DEBOUNCE_CYC_DEF`, `KEY_LONG_CYC_DEF`, `KEY_REPEAT_CYC_DEF`.
- **Sub-module `key_filter_chan`:** one channel (synchroniser, debounce counter, pulses, hold FSM). It is instantiated `N_KEYS` times in a generate loop; the top level contains only the loop and the bit slicing.

## Test plan
Bench parameters: `N_KEYS=2`, `DEBOUNCE_CYC=4`, `LONG_CYC=20`, `REPEAT_CYC=8`, `ACTIVE_LOW=1`.
- **Clean press:** drive `key[0]` 1→0 and hold → `key_level[0]` rises and `key_press[0]` pulses for one cycle, exactly 6 cycles after the first capturing edge. `key[1]` outputs stay 0.
- **Bounce:** low for 3 cycles, high for 1, low for 3, then held low → no `key_press` until 4 consecutive low `raw` cycles. Exactly one `key_press[0]`.
- **Long and repeat:** hold `key[0]` for 60 cycles after `key_press` → `key_long` at +20; `key_repeat` at +28, +36, +44, +52. Release → one `key_release`, and no further pulses.
- **Release on boundary:** release timed so `key_release` lands in the cycle `hold_cnt` reaches 19 → no `key_long`. FSM returns to IDLE.
- **Simultaneous keys:** press `key[0]` and `key[1]` in the same cycle → `key_press=2'b11` in one cycle. The long-press pulses are also simultaneous.
- **Reset mid-hold:** assert `rst_n=0` for 2 cycles while in LONG with the key still held → all outputs 0 immediately after the reset edge. A fresh `key_press` follows 6 cycles after release of reset (2 synchroniser + 4 debounce, because the synchroniser resets to the released level).

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared hold-state encodings and default timing for the key filter bank
package key_pkg;
  typedef enum logic [1:0] {
    KEY_ST_IDLE = 2'd0,
    KEY_ST_HELD = 2'd1,
    KEY_ST_LONG = 2'd2
  } key_st_e;
  localparam int KEY_DEBOUNCE_CYC_DEF = 1_000_000;
  localparam int KEY_LONG_CYC_DEF     = 50_000_000;
  localparam int KEY_REPEAT_CYC_DEF   = 10_000_000;
endpackage

// File: rtl/key_filter_chan.sv
// key_filter_chan: one key channel - synchroniser, debounce, press/release pulses, hold FSM
// Hold FSM (long press / auto-repeat) is built only when KEY_LONG_PRESS_EN is defined.
module key_filter_chan
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = KEY_DEBOUNCE_CYC_DEF,
  parameter int LONG_CYC     = KEY_LONG_CYC_DEF,
  parameter int REPEAT_CYC   = KEY_REPEAT_CYC_DEF,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);
  localparam logic REL = 1'(ACTIVE_LOW != 0);
  localparam int   DW  = $clog2(DEBOUNCE_CYC + 1);
  logic          r_d0, r_d1, r_level, r_press, r_release;
  logic [DW-1:0] r_cnt;
  logic          w_raw, w_done;
  // xor with the released level maps the pin to pressed = 1
  assign w_raw  = r_d1 ^ REL;
  assign w_done = (w_raw != r_level) && (r_cnt == DW'(DEBOUNCE_CYC - 1));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d0      <= REL;
      r_d1      <= REL;
      r_level   <= 1'b0;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_d0      <= i_key;
      r_d1      <= r_d0;
      r_cnt     <= (w_raw == r_level || w_done) ? '0 : r_cnt + 1'b1;
      r_level   <= w_done ? w_raw : r_level;
      r_press   <= w_done & w_raw;
      r_release <= w_done & ~w_raw;
    end
  end
  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
`ifdef KEY_LONG_PRESS_EN
  localparam int HMAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int HW   = $clog2(HMAX + 1);
  key_st_e       r_st, w_st_nxt;
  logic [HW-1:0] r_hcnt, w_hcnt_nxt;
  logic          r_long, r_repeat, w_long_nxt, w_repeat_nxt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st     <= KEY_ST_IDLE;
      r_hcnt   <= '0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
    end else begin
      r_st     <= w_st_nxt;
      r_hcnt   <= w_hcnt_nxt;
      r_long   <= w_long_nxt;
      r_repeat <= w_repeat_nxt;
    end
  end
  // release shares the edge that registers key_release, so it masks any coinciding pulse
  always_comb begin
    w_st_nxt     = r_st;
    w_hcnt_nxt   = r_hcnt;
    w_long_nxt   = 1'b0;
    w_repeat_nxt = 1'b0;
    if (w_done && !w_raw) begin
      w_st_nxt   = KEY_ST_IDLE;
      w_hcnt_nxt = '0;
    end else if (r_st == KEY_ST_IDLE) begin
      w_st_nxt   = (w_done && w_raw) ? KEY_ST_HELD : KEY_ST_IDLE;
      w_hcnt_nxt = '0;
    end else if (r_st == KEY_ST_HELD) begin
      w_long_nxt = (r_hcnt == HW'(LONG_CYC - 1));
      w_st_nxt   = w_long_nxt ? KEY_ST_LONG : KEY_ST_HELD;
      w_hcnt_nxt = w_long_nxt ? '0 : r_hcnt + 1'b1;
    end else if (r_st == KEY_ST_LONG && REPEAT_CYC != 0) begin
      w_repeat_nxt = (r_hcnt == HW'(REPEAT_CYC - 1));
      w_hcnt_nxt   = w_repeat_nxt ? '0 : r_hcnt + 1'b1;
    end
  end
  assign o_long   = r_long;
  assign o_repeat = r_repeat;
`else
  assign o_long   = 1'b0;
  assign o_repeat = 1'b0;
`endif
endmodule

// File: rtl/key_filter_bank.sv
// key_filter_bank: N_KEYS independent debounced key channels for the user panel
// Long-press / auto-repeat outputs are live only when KEY_LONG_PRESS_EN is defined.
module key_filter_bank
  import key_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int DEBOUNCE_CYC = KEY_DEBOUNCE_CYC_DEF,
  parameter int LONG_CYC     = KEY_LONG_CYC_DEF,
  parameter int REPEAT_CYC   = KEY_REPEAT_CYC_DEF,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);
  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_filter_chan #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .REPEAT_CYC  (REPEAT_CYC),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_key    (key[i]),
      .o_level  (key_level[i]),
      .o_press  (key_press[i]),
      .o_release(key_release[i]),
      .o_long   (key_long[i]),
      .o_repeat (key_repeat[i])
    );
  end
endmodule

// File: tb/tb_key_filter_bank.sv
// tb_key_filter_bank: directed checks of debounce, pulses, hold timing and reset for key_filter_bank
module tb_key_filter_bank;
`ifdef KEY_LONG_PRESS_EN
  localparam logic LP = 1'b1;
`else
  localparam logic LP = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key;
  logic [1:0] key_level, key_press, key_release, key_long, key_repeat;
  int         n_vec = 0;
  int         n_err = 0;
  key_filter_bank #(
    .N_KEYS      (2),
    .DEBOUNCE_CYC(4),
    .LONG_CYC    (20),
    .REPEAT_CYC  (8),
    .ACTIVE_LOW  (1)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_repeat (key_repeat)
  );
  always #5 clk = ~clk;
  function automatic logic [9:0] v(input logic [1:0] l, p, r, g, t);
    return {l, p, r, g, t};
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // order: level, press, release, long, repeat
  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {key_level, key_press, key_release, key_long, key_repeat};
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    key   = 2'b11;
    tick(3);
    chk("reset", v(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    tick(2);
    chk("idle", v(0, 0, 0, 0, 0));
    // clean press: capture edge e0, level/press at e5
    key[0] = 1'b0;
    tick(5);
    chk("pre_press", v(0, 0, 0, 0, 0));
    tick(1);
    chk("clean_press", v(2'b01, 2'b01, 0, 0, 0));
    // hold, release after +60: long at +20, repeats every 8, release at +66
    for (int k = 1; k <= 75; k++) begin
      tick(1);
      chk("hold", v(k < 66 ? 2'b01 : 2'b00, 2'b00, k == 66 ? 2'b01 : 2'b00,
                    (k == 20) ? {1'b0, LP} : 2'b00,
                    (k > 20 && (k - 20) % 8 == 0 && k < 66) ? {1'b0, LP} : 2'b00));
      if (k == 60) key[0] = 1'b1;
    end
    // bounce: pin low 3, high 1, then low; press lands on edge 9
    for (int c = 0; c < 16; c++) begin
      key[0] = (c == 3);
      tick(1);
      chk("bounce", v(c >= 9 ? 2'b01 : 2'b00, c == 9 ? 2'b01 : 2'b00, 0, 0, 0));
    end
    key[0] = 1'b1;
    tick(10);
    chk("bounce_idle", v(0, 0, 0, 0, 0));
    // release landing on the long boundary suppresses key_long
    key[0] = 1'b0;
    tick(6);
    chk("bnd_press", v(2'b01, 2'b01, 0, 0, 0));
    tick(14);
    key[0] = 1'b1;
    for (int k = 15; k <= 45; k++) begin
      tick(1);
      chk("boundary", v(k < 20 ? 2'b01 : 2'b00, 2'b00, k == 20 ? 2'b01 : 2'b00, 2'b00, 2'b00));
    end
    // simultaneous keys
    key = 2'b00;
    tick(6);
    chk("sim_press", v(2'b11, 2'b11, 0, 0, 0));
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      chk("sim_long", v(2'b11, 2'b00, 2'b00, (k == 20) ? {LP, LP} : 2'b00, 2'b00));
    end
    tick(3);
    // reset while in LONG with keys held
    rst_n = 1'b0;
    tick(1);
    chk("rst_edge", v(0, 0, 0, 0, 0));
    tick(1);
    chk("rst_hold", v(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    tick(5);
    chk("rst_sync", v(0, 0, 0, 0, 0));
    tick(1);
    chk("rst_repress", v(2'b11, 2'b11, 0, 0, 0));
    key = 2'b11;
    tick(10);
    chk("final_idle", v(0, 0, 0, 0, 0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
